// File: rtl/lut_prog_pkg.sv
// Shared types and constants for the programmable lookup table.
package lut_prog_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // Default contents reproduce the legacy fixed LUT: y=1 for x in {4,8,10}.
   localparam logic [15:0] LUT_INIT_DEFAULT = 16'h0510;

endpackage

// File: rtl/lut_prog.sv
// Register-based programmable LUT with a one-deep valid/ready result stage
// and a self-test sweep that streams every entry and counts non-zero ones.
//
// state | meaning
// IDLE  | external lookups and writes accepted; sweep_start launches a sweep
// SWEEP | internal counter issues addresses 0..DEPTH-1 into the stage
// DRAIN | last sweep result still in the stage; wait until it is taken
module lut_prog
   import lut_prog_pkg::*;
#(
   parameter int                          N_IN  = 4,
   parameter int                          M_OUT = 1,
   parameter logic [(2**N_IN)*M_OUT-1:0]  INIT  = LUT_INIT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   output logic              wr_ready,
   input  logic [N_IN-1:0]   wr_addr,
   input  logic [M_OUT-1:0]  wr_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_IN-1:0]   x,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [M_OUT-1:0]  y,
   output logic [N_IN-1:0]   y_addr,
   input  logic              sweep_start,
   output logic              sweep_busy,
   output logic              sweep_done,
   output logic [N_IN:0]     hit_cnt
);

   localparam int                DEPTH    = 2**N_IN;
   localparam int                CNT_W    = N_IN + 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   state_e             state_q, state_d;
   logic [M_OUT-1:0]   tbl_q [DEPTH];
   logic [M_OUT-1:0]   tbl_d [DEPTH];
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   hit_q, hit_d;
   logic               out_valid_q, out_valid_d;
   logic [M_OUT-1:0]   y_q, y_d;
   logic [N_IN-1:0]    y_addr_q, y_addr_d;
   logic               sweep_tag_q, sweep_tag_d;
   logic               done_q, done_d;

   logic               stage_free;
   logic               load_ext;
   logic               load_sw;
   logic [N_IN-1:0]    load_addr;

   always_comb begin
      stage_free = !out_valid_q || out_ready;
      wr_ready   = (state_q == IDLE);
      // A sweep request takes priority over an external lookup in the same cycle.
      in_ready   = (state_q == IDLE) && stage_free && !sweep_start;
      load_ext   = in_valid && in_ready;
      load_sw    = (state_q == SWEEP) && stage_free;
      load_addr  = load_sw ? cnt_q[N_IN-1:0] : x;
   end

   always_comb begin
      tbl_d = tbl_q;
      if (wr_en && wr_ready) begin
         tbl_d[wr_addr] = wr_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hit_d       = hit_q;
      done_d      = 1'b0;
      out_valid_d = out_valid_q;
      y_d         = y_q;
      y_addr_d    = y_addr_q;
      sweep_tag_d = sweep_tag_q;

      // Reads use tbl_q, so a same-cycle write to the same entry is not seen.
      if (load_ext || load_sw) begin
         out_valid_d = 1'b1;
         y_d         = tbl_q[load_addr];
         y_addr_d    = load_addr;
         sweep_tag_d = load_sw;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (out_valid_q && out_ready && sweep_tag_q && (|y_q)) begin
         hit_d = hit_q + CNT_ONE;
      end

      case (state_q)
         IDLE: begin
            if (sweep_start) begin
               state_d = SWEEP;
               cnt_d   = '0;
               hit_d   = '0;
            end
         end
         SWEEP: begin
            if (load_sw) begin
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (stage_free) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hit_q       <= '0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         y_addr_q    <= '0;
         sweep_tag_q <= 1'b0;
         done_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            tbl_q[i] <= INIT[i*M_OUT +: M_OUT];
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hit_q       <= hit_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         y_addr_q    <= y_addr_d;
         sweep_tag_q <= sweep_tag_d;
         done_q      <= done_d;
         tbl_q       <= tbl_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign y          = y_q;
   assign y_addr     = y_addr_q;
   assign sweep_busy = (state_q != IDLE);
   assign sweep_done = done_q;
   assign hit_cnt    = hit_q;

endmodule
